// File: rtl/vme_regbank_pkg.sv
// Shared constants and helpers for the VME register bank.
package vme_regbank_pkg;

    typedef enum logic {
        ACC_RW = 1'b0,
        ACC_RO = 1'b1
    } acc_e;

    // Smallest word-address width that covers n_regs registers (n_regs <= 64).
    function automatic int calc_addr_w(input int n_regs);
        int w;
        w = 1;
        for (int i = 1; i < 7; i++)
            if ((1 << w) < n_regs) w++;
        return w;
    endfunction

    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/vme_regbank_pipe_stage.sv
// Parametrised-width pipeline register with load enable and async active-low clear.
module vme_regbank_pipe_stage #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/vme_regbank_pipe.sv
// Parametrised VME register bank with optional write-input / read-output stages.
// Optional error outputs VMERdErr/VMEWrErr are enabled by defining VME_REGBANK_ERR_EN.
module vme_regbank_pipe
    import vme_regbank_pkg::*;
#(
    parameter int                       N_REGS      = 4,
    parameter int                       DATA_W      = 16,
    parameter int                       ADDR_W      = 2,
    parameter logic [N_REGS-1:0]        RO_MASK     = '0,
    parameter logic [N_REGS*DATA_W-1:0] RST_VAL     = '0,
    parameter int                       PIPE_WR_IN  = 1,
    parameter int                       PIPE_RD_OUT = 1
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [ADDR_W:1]            VMEAddr,
    output logic [DATA_W-1:0]          VMERdData,
    input  logic [DATA_W-1:0]          VMEWrData,
    input  logic                       VMERdMem,
    input  logic                       VMEWrMem,
    output logic                       VMERdDone,
    output logic                       VMEWrDone,
`ifdef VME_REGBANK_ERR_EN
    output logic                       VMERdErr,
    output logic                       VMEWrErr,
`endif
    output logic [N_REGS*DATA_W-1:0]   regs_o,
    input  logic [N_REGS*DATA_W-1:0]   regs_i,
    output logic [N_REGS-1:0]          regs_wstb_o
);

    localparam int WS_W = 1 + ADDR_W + DATA_W;

    logic [WS_W-1:0]                 ws_d, ws_q;
    logic                            s0_vld;
    logic [ADDR_W-1:0]               s0_addr;
    logic [DATA_W-1:0]               s0_data;
    logic [N_REGS-1:0]               wr_hit;
    logic [N_REGS-1:0][DATA_W-1:0]   rw_q;
    logic                            wr_err_q;
    logic [DATA_W-1:0]               rd_mux;
    logic                            rd_mapped;
    logic                            rd_err;
    logic                            rd_err_q;

    // Write stage 0: either the raw bus or the bus delayed by one cycle.
    assign ws_d = {VMEWrMem, VMEAddr, VMEWrData};

    generate
        if (PIPE_WR_IN != 0) begin : g_wr_pipe
            vme_regbank_pipe_stage #(.W(WS_W)) u_wr_stage (
                .Clk   (Clk),
                .Rst_n (Rst_n),
                .en    (1'b1),
                .d     (ws_d),
                .q     (ws_q)
            );
        end else begin : g_wr_comb
            assign ws_q = ws_d;
        end
    endgenerate

    assign {s0_vld, s0_addr, s0_data} = ws_q;

    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < N_REGS; k++)
            if (s0_vld && s0_addr == ADDR_W'(k) && acc_e'(RO_MASK[k]) == ACC_RW)
                wr_hit[k] = 1'b1;
    end

    // RO entries never see a hit, so they stay at zero and drop out in synthesis.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < N_REGS; k++)
                rw_q[k] <= RO_MASK[k] ? '0 : RST_VAL[slice_lo(k, DATA_W) +: DATA_W];
        end else begin
            for (int k = 0; k < N_REGS; k++)
                if (wr_hit[k]) rw_q[k] <= s0_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regs_wstb_o <= '0;
            VMEWrDone   <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            regs_wstb_o <= wr_hit;
            VMEWrDone   <= s0_vld;
            wr_err_q    <= s0_vld & ~|wr_hit;
        end
    end

    assign regs_o = rw_q;

    always_comb begin
        rd_mux    = '0;
        rd_mapped = 1'b0;
        for (int k = 0; k < N_REGS; k++)
            if (VMEAddr == ADDR_W'(k)) begin
                rd_mapped = 1'b1;
                rd_mux    = RO_MASK[k] ? regs_i[slice_lo(k, DATA_W) +: DATA_W] : rw_q[k];
            end
    end

    assign rd_err = VMERdMem & ~rd_mapped;

    generate
        if (PIPE_RD_OUT != 0) begin : g_rd_pipe
            // Data only loads on a request so it holds between reads.
            vme_regbank_pipe_stage #(.W(DATA_W)) u_rd_data (
                .Clk   (Clk),
                .Rst_n (Rst_n),
                .en    (VMERdMem),
                .d     (rd_mux),
                .q     (VMERdData)
            );
            vme_regbank_pipe_stage #(.W(2)) u_rd_ack (
                .Clk   (Clk),
                .Rst_n (Rst_n),
                .en    (1'b1),
                .d     ({VMERdMem, rd_err}),
                .q     ({VMERdDone, rd_err_q})
            );
        end else begin : g_rd_comb
            assign VMERdData = VMERdMem ? rd_mux : '0;
            assign VMERdDone = VMERdMem;
            assign rd_err_q  = rd_err;
        end
    endgenerate

`ifdef VME_REGBANK_ERR_EN
    assign VMERdErr = rd_err_q;
    assign VMEWrErr = wr_err_q;
`else
    logic unused_err;
    assign unused_err = rd_err_q ^ wr_err_q;
`endif

endmodule

// File: tb/tb_vme_regbank_pipe.sv
// Bench for vme_regbank_pipe: three configurations share one bus and are checked against a transaction model.
module tb_vme_regbank_pipe;
    import vme_regbank_pkg::*;

    localparam logic [63:0] RST0 = {16'h0000, 16'h1234, 16'hBEEF, 16'h0001};

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [2:1]  VMEAddr = '0;
    logic [15:0] VMEWrData = '0;
    logic        VMERdMem = 1'b0;
    logic        VMEWrMem = 1'b0;

    logic [15:0] rdata0, rdata1, rdata2;
    logic        rdd0, rdd1, rdd2, wrd0, wrd1, wrd2;
    logic [63:0] regs0, regs2;
    logic [47:0] regs1;
    logic [3:0]  wstb0, wstb2;
    logic [2:0]  wstb1;
    logic [63:0] regsi0 = {16'h5A5A, 16'hDEAD, 16'hDEAD, 16'hDEAD};
    logic [47:0] regsi1 = 48'hCAFE_CAFE_CAFE;
    logic [63:0] regsi2 = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef VME_REGBANK_ERR_EN
    logic        rerr0, rerr1, rerr2, werr0, werr1, werr2;
`endif

    always #5 Clk = ~Clk;

    vme_regbank_pipe #(.N_REGS(4), .DATA_W(16), .ADDR_W(calc_addr_w(4)), .RO_MASK(4'b1000),
                       .RST_VAL(RST0), .PIPE_WR_IN(1), .PIPE_RD_OUT(1)) u_d0 (
        .Clk(Clk), .Rst_n(Rst_n), .VMEAddr(VMEAddr), .VMERdData(rdata0), .VMEWrData(VMEWrData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdDone(rdd0), .VMEWrDone(wrd0),
`ifdef VME_REGBANK_ERR_EN
        .VMERdErr(rerr0), .VMEWrErr(werr0),
`endif
        .regs_o(regs0), .regs_i(regsi0), .regs_wstb_o(wstb0));

    vme_regbank_pipe #(.N_REGS(3), .DATA_W(16), .ADDR_W(calc_addr_w(3)), .RO_MASK(3'b000),
                       .RST_VAL(48'h0), .PIPE_WR_IN(1), .PIPE_RD_OUT(1)) u_d1 (
        .Clk(Clk), .Rst_n(Rst_n), .VMEAddr(VMEAddr), .VMERdData(rdata1), .VMEWrData(VMEWrData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdDone(rdd1), .VMEWrDone(wrd1),
`ifdef VME_REGBANK_ERR_EN
        .VMERdErr(rerr1), .VMEWrErr(werr1),
`endif
        .regs_o(regs1), .regs_i(regsi1), .regs_wstb_o(wstb1));

    vme_regbank_pipe #(.N_REGS(4), .DATA_W(16), .ADDR_W(2), .RO_MASK(4'b0000),
                       .RST_VAL(64'h0), .PIPE_WR_IN(0), .PIPE_RD_OUT(0)) u_d2 (
        .Clk(Clk), .Rst_n(Rst_n), .VMEAddr(VMEAddr), .VMERdData(rdata2), .VMEWrData(VMEWrData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdDone(rdd2), .VMEWrDone(wrd2),
`ifdef VME_REGBANK_ERR_EN
        .VMERdErr(rerr2), .VMEWrErr(werr2),
`endif
        .regs_o(regs2), .regs_i(regsi2), .regs_wstb_o(wstb2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct {
        int          due;
        int          d;
        bit          wr;
        int          addr;
        logic [15:0] data;
        bit          err;
    } ev_t;

    int          nr[3]  = '{4, 3, 4};
    logic [3:0]  rom[3] = '{4'b1000, 4'b0000, 4'b0000};
    int          pw[3]  = '{1, 1, 0};
    int          pr[3]  = '{1, 1, 0};
    logic [63:0] rst0_v = RST0;
    logic [15:0] mreg[3][4];
    logic [15:0] hold[3];
    ev_t         q[$];
    int          cyc = 0;

    function automatic logic [15:0] model_rd(input int d, input int a);
        logic [63:0] src;
        src = (d == 0) ? regsi0 : (d == 1) ? {16'h0, regsi1} : regsi2;
        if (a >= nr[d]) return 16'h0;
        if (rom[d][a]) return src[a*16 +: 16];
        return mreg[d][a];
    endfunction

    function automatic logic [63:0] model_regs(input int d);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nr[d]; k++)
            if (!rom[d][k]) v[k*16 +: 16] = mreg[d][k];
        return v;
    endfunction

    bit          ewd[3], erd[3], ewe[3], ere[3];
    logic [3:0]  ewstb[3];
    logic [63:0] a_regs[3];
    logic [3:0]  a_wstb[3];
    logic        a_wd[3], a_rd[3];
    logic [15:0] a_rdata[3];
    ev_t         e;

    always @(negedge Clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            ewd[d] = 0; erd[d] = 0; ewe[d] = 0; ere[d] = 0; ewstb[d] = '0;
        end
        if (!Rst_n) begin
            q.delete();
            for (int d = 0; d < 3; d++) begin
                hold[d] = '0;
                for (int k = 0; k < 4; k++)
                    mreg[d][k] = (d == 0) ? rst0_v[k*16 +: 16] : 16'h0;
            end
        end else begin
            foreach (q[i])
                if (q[i].wr && q[i].due == cyc) begin
                    ewd[q[i].d] = 1;
                    if (q[i].addr < nr[q[i].d] && !rom[q[i].d][q[i].addr]) begin
                        mreg[q[i].d][q[i].addr] = q[i].data;
                        ewstb[q[i].d][q[i].addr] = 1'b1;
                    end else ewe[q[i].d] = 1;
                end
            for (int d = 0; d < 3; d++) begin
                if (VMEWrMem) begin
                    e = '{due: cyc + 1 + pw[d], d: d, wr: 1, addr: int'(VMEAddr), data: VMEWrData, err: 0};
                    q.push_back(e);
                end
                if (VMERdMem) begin
                    e = '{due: cyc + pr[d], d: d, wr: 0, addr: int'(VMEAddr),
                          data: model_rd(d, int'(VMEAddr)), err: (int'(VMEAddr) >= nr[d])};
                    q.push_back(e);
                end
            end
            foreach (q[i])
                if (!q[i].wr && q[i].due == cyc) begin
                    erd[q[i].d] = 1;
                    hold[q[i].d] = q[i].data;
                    ere[q[i].d] = q[i].err;
                end
            q = q.find(x) with (x.due > cyc);
        end

        a_regs[0] = regs0; a_regs[1] = {16'h0, regs1}; a_regs[2] = regs2;
        a_wstb[0] = wstb0; a_wstb[1] = {1'b0, wstb1}; a_wstb[2] = wstb2;
        a_wd[0] = wrd0; a_wd[1] = wrd1; a_wd[2] = wrd2;
        a_rd[0] = rdd0; a_rd[1] = rdd1; a_rd[2] = rdd2;
        a_rdata[0] = rdata0; a_rdata[1] = rdata1; a_rdata[2] = rdata2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("c%0d_d%0d_wrdone", cyc, d), 64'(a_wd[d]), 64'(ewd[d]));
            chk($sformatf("c%0d_d%0d_wstb", cyc, d), 64'(a_wstb[d]), 64'(ewstb[d]));
            chk($sformatf("c%0d_d%0d_regs", cyc, d), a_regs[d], model_regs(d));
            chk($sformatf("c%0d_d%0d_rddone", cyc, d), 64'(a_rd[d]), 64'(erd[d]));
            if (pr[d] != 0 || erd[d])
                chk($sformatf("c%0d_d%0d_rddata", cyc, d), 64'(a_rdata[d]), 64'(hold[d]));
        end
`ifdef VME_REGBANK_ERR_EN
        chk($sformatf("c%0d_d0_rderr", cyc), 64'(rerr0), 64'(ere[0]));
        chk($sformatf("c%0d_d1_rderr", cyc), 64'(rerr1), 64'(ere[1]));
        chk($sformatf("c%0d_d2_rderr", cyc), 64'(rerr2), 64'(ere[2]));
        chk($sformatf("c%0d_d0_wrerr", cyc), 64'(werr0), 64'(ewe[0]));
        chk($sformatf("c%0d_d1_wrerr", cyc), 64'(werr1), 64'(ewe[1]));
        chk($sformatf("c%0d_d2_wrerr", cyc), 64'(werr2), 64'(ewe[2]));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic rd, input logic wr, input int a, input logic [15:0] dat);
        @(posedge Clk);
        #1;
        VMERdMem  = rd;
        VMEWrMem  = wr;
        VMEAddr   = 2'(a);
        VMEWrData = dat;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_regs0", regs0, 64'h0000_1234_BEEF_0001);
        chk("rst_rdata0", 64'(rdata0), 64'h0);
        chk("rst_dones0", {62'h0, rdd0, wrd0}, 64'h0);
        chk("rst_wstb0", 64'(wstb0), 64'h0);
        Rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        step(0, 1, 2, 16'hA5A5);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("wr_fast_done", 64'(wrd2), 64'h1);
        chk("wr_fast_reg", 64'(regs2[47:32]), 64'hA5A5);
        chk("wr_pipe_early", 64'(wrd0), 64'h0);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("wr_pipe_done", 64'(wrd0), 64'h1);
        chk("wr_pipe_wstb", 64'(wstb0), 64'h4);
        chk("wr_pipe_reg", 64'(regs0[47:32]), 64'hA5A5);

        step(1, 0, 2, 0);
        @(negedge Clk);
        chk("rd_fast_done", 64'(rdd2), 64'h1);
        chk("rd_fast_data", 64'(rdata2), 64'hA5A5);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("rd_pipe_done", 64'(rdd0), 64'h1);
        chk("rd_pipe_data", 64'(rdata0), 64'hA5A5);

        step(1, 0, 3, 0);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("rd_ro_data", 64'(rdata0), 64'h5A5A);
        chk("rd_unmapped_data", 64'(rdata1), 64'h0);
        chk("rd_unmapped_done", 64'(rdd1), 64'h1);

        step(0, 1, 3, 16'hFFFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("wr_ro_done", 64'(wrd0), 64'h1);
        chk("wr_ro_wstb", 64'(wstb0), 64'h0);
        chk("wr_unmapped_done", 64'(wrd1), 64'h1);
        chk("wr_unmapped_wstb", 64'(wstb1), 64'h0);
        step(1, 0, 3, 0);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("rd_ro_after_wr", 64'(rdata0), 64'h5A5A);

        for (int i = 0; i < 4; i++) step(0, 1, i, 16'(16'h1111 * (i + 1)));
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("b2b_regs2", regs2, 64'h4444_3333_2222_1111);
        chk("b2b_regs0", regs0, 64'h0000_3333_2222_1111);
        chk("b2b_regs1", 64'(regs1), 64'h3333_2222_1111);
        for (int i = 0; i < 4; i++) step(1, 0, i, 0);
        step(0, 0, 0, 0);

        step(1, 1, 1, 16'h7777);
        step(1, 0, 1, 0);
        @(negedge Clk);
        chk("raw_same_cycle", 64'(rdata0), 64'h2222);
        step(1, 0, 1, 0);
        @(negedge Clk);
        chk("raw_one_later", 64'(rdata0), 64'h2222);
        step(0, 0, 0, 0);
        @(negedge Clk);
        chk("raw_two_later", 64'(rdata0), 64'h7777);

        step(0, 1, 0, 16'h9999);
        @(posedge Clk);
        #1;
        Rst_n    = 1'b0;
        VMEWrMem = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (4) step(0, 0, 0, 0);
        @(negedge Clk);
        chk("midrst_reg0", 64'(regs0[15:0]), 64'h0001);
        chk("midrst_reg0_fast", 64'(regs2[15:0]), 64'h0000);

        step(1, 1, 3, 16'h0BAD);
        repeat (4) step(0, 0, 0, 0);
        @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
